// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// Bytes are sampled at bit centres from a synchronised copy of the line and
// delivered over a valid/ready handshake. Bad stop bits and bytes lost to a
// full FIFO are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] data_rx,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   OCC_MAX  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [1:0]       sync_q;
  logic             rx_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push;
  logic             ferr;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Two-flop synchroniser; preset high so reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_in};
    end
  end

  assign rx_s = sync_q[1];

  // Receiver control registers; a reset mid-frame simply abandons the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Shift register holds only data, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Next-state logic: half-bit wait for the start bit, then one bit period per sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is already gone by mid-bit was a glitch.
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            // Line held low (break or miswired link): wait for it to return high.
            ferr    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign valid     = (occ_q != '0);
  assign full      = (occ_q == OCC_MAX);
  assign pop       = valid && ready;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign frame_err = ferr;
  assign data_rx   = valid ? mem[rd_ptr_q] : 8'h00;

  // FIFO storage; written with the completed shift register on a good stop bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + (PTR_W + 1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W + 1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and compares its
// outputs every cycle against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  // Cycles from driving a start bit to the stop-bit sample: 2 sync flops,
  // one cycle to leave IDLE, half a bit to the start centre, nine more bits.
  localparam int FRAME_LAT = 3 + CPB / 2 + 9 * CPB - 1;

  logic       clk;
  logic       reset;
  logic       uart_in;
  logic [7:0] data_rx;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overflow;

  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  int         cyc;
  int         n_checks;
  int         n_errs;
  int         ferr_cnt;
  int         ovf_cnt;
  int         last_ev;

  uart_rx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_in  (uart_in),
    .data_rx  (data_rx),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial frame, LSB first; the frame's stop sample is registered with the model.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    step();
    last_ev = cyc + 1 + FRAME_LAT;
    e.cyc = last_ev;
    e.b   = b;
    e.ok  = stop_ok;
    sched.push_back(e);
    uart_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) step();
      uart_in = b[i];
    end
    repeat (CPB) step();
    uart_in = stop_ok;
    repeat (CPB) step();
    uart_in = 1'b1;
  endtask

  task automatic drain(input int n);
    ready = 1'b1;
    repeat (n) step();
    ready = 1'b0;
    step();
  endtask

  task automatic check_popped(input string name, input logic [7:0] exp_q[$]);
    chk({name, "_count"}, 32'(popped.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(name, (i < popped.size()) ? 32'(popped[i]) : 32'h100, 32'(exp_q[i]));
    end
    popped.delete();
  endtask

  // Per-cycle compare: outputs reflect the model state after the last edge;
  // then the model applies this cycle's pop and scheduled stop-bit event.
  initial begin : compare
    ev_t        e;
    bit         exp_push;
    bit         exp_ferr;
    bit         exp_ovf;
    bit         m_pop;
    logic [7:0] eb;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_data_rx", 32'(data_rx), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        mq.delete();
        sched.delete();
      end else begin
        exp_push = 1'b0;
        exp_ferr = 1'b0;
        eb       = 8'h00;
        if (sched.size() > 0 && sched[0].cyc == cyc) begin
          e = sched.pop_front();
          eb = e.b;
          if (e.ok) exp_push = 1'b1;
          else      exp_ferr = 1'b1;
        end
        chk("valid", 32'(valid), (mq.size() > 0) ? 32'h1 : 32'h0);
        chk("data_rx", 32'(data_rx), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        if (valid && ready) popped.push_back(data_rx);
        if (frame_err) ferr_cnt++;
        if (overflow) ovf_cnt++;
        m_pop   = (mq.size() > 0) && ready;
        exp_ovf = exp_push && (mq.size() == DEPTH) && !m_pop;
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (m_pop) void'(mq.pop_front());
        if (exp_push && !exp_ovf) mq.push_back(eb);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0;
    int o0;
    int ev;
    int guard;
    n_checks = 0;
    n_errs   = 0;
    ferr_cnt = 0;
    ovf_cnt  = 0;
    last_ev  = 0;
    reset    = 1'b1;
    uart_in  = 1'b1;
    ready    = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    repeat (10) step();

    // Single byte held until accepted.
    send_byte(8'h55, 1'b1);
    repeat (20) step();
    chk("t1_valid_held", 32'(valid), 32'h1);
    chk("t1_data_held", 32'(data_rx), 32'h55);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    chk("t1_valid_after_pop", 32'(valid), 32'h0);
    chk("t1_data_after_pop", 32'(data_rx), 32'h0);
    check_popped("t1_pop", '{8'h55});

    // Short low glitch: no byte, no flag.
    f0 = ferr_cnt;
    uart_in = 1'b0;
    repeat (3) step();
    uart_in = 1'b1;
    repeat (40) step();
    chk("t2_ferr", 32'(ferr_cnt - f0), 32'h0);
    chk("t2_valid", 32'(valid), 32'h0);

    // Bad stop bit, then a clean byte.
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0);
    chk("t3_ferr", 32'(ferr_cnt - f0), 32'h1);
    chk("t3_valid", 32'(valid), 32'h0);
    repeat (20) step();
    send_byte(8'h3C, 1'b1);
    repeat (5) step();
    chk("t3_data", 32'(data_rx), 32'h3C);
    drain(3);
    check_popped("t3_pop", '{8'h3C});

    // Five back-to-back bytes into a 4-entry FIFO.
    o0 = ovf_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (5) step();
    chk("t4_ovf", 32'(ovf_cnt - o0), 32'h1);
    drain(6);
    check_popped("t4_pop", '{8'h01, 8'h02, 8'h03, 8'h04});

    // Full FIFO, pop in the same cycle as the push.
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    fork
      send_byte(8'h06, 1'b1);
      begin
        step();
        #1;
        ev = last_ev;
        guard = 0;
        while (cyc + 1 != ev && guard < 300) begin
          step();
          guard++;
        end
        if (guard >= 300) begin
          n_checks++;
          n_errs++;
          $display("FAIL t5_align: push cycle %0d not reached, at cycle %0d", ev, cyc);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
      end
    join
    repeat (5) step();
    chk("t5_ovf", 32'(ovf_cnt - o0), 32'h0);
    check_popped("t5_simul_pop", '{8'h01});
    drain(6);
    check_popped("t5_pop", '{8'h02, 8'h03, 8'h04, 8'h06});

    // Reset mid-frame with the line low, FIFO holding a byte.
    send_byte(8'h99, 1'b1);
    repeat (5) step();
    chk("t6_pre_valid", 32'(valid), 32'h1);
    uart_in = 1'b0;
    repeat (35) step();
    reset = 1'b1;
    repeat (3) step();
    chk("t6_rst_valid", 32'(valid), 32'h0);
    chk("t6_rst_data", 32'(data_rx), 32'h0);
    reset = 1'b0;
    begin
      ev_t e;
      // Releasing reset into a low line looks like a start edge that never ends.
      e.cyc = cyc + 1 + FRAME_LAT;
      e.b   = 8'h00;
      e.ok  = 1'b0;
      sched.push_back(e);
    end
    f0 = ferr_cnt;
    repeat (150) step();
    chk("t6_low_valid", 32'(valid), 32'h0);
    uart_in = 1'b1;
    repeat (30) step();
    chk("t6_ferr", 32'(ferr_cnt - f0), 32'h1);
    send_byte(8'h7E, 1'b1);
    repeat (5) step();
    chk("t6_data", 32'(data_rx), 32'h7E);
    drain(3);
    check_popped("t6_pop", '{8'h7E});

    // Random bytes with random stop bits and random consumer back-pressure.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
          repeat ($urandom_range(0, 3)) step();
          if (!uart_in) uart_in = 1'b1;
        end
      end
      begin
        for (int i = 0; i < 1300; i++) begin
          ready = ($urandom_range(0, 3) == 0);
          step();
        end
        ready = 1'b0;
      end
    join
    drain(8);
    chk("rand_empty", 32'(valid), 32'h0);

    repeat (10) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
